// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared constants for the handshaked ALU execution unit:
//            default datapath width, opcode map and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] OP_NOT = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_iter_mul.sv
`default_nettype none
// ============================================================================
// Module   : alu_iter_mul
// Brief    : Shift-add multiplier core. i_start loads the operands and clears
//            the accumulator; every i_step cycle adds the shifted multiplicand
//            when the current multiplier LSB is set. The sequencing (how many
//            steps) is owned by the caller.
// Revision : 1.0 - initial release
// ============================================================================
module alu_iter_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_acc_next
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;

    // Accumulator value after the current step; the caller latches this on
    // the final step so the product is ready without an extra cycle.
    assign o_acc_next = r_acc + (r_b[0] ? r_a : '0);

    // Load on start, otherwise shift multiplicand left / multiplier right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
        end else if (i_step) begin
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_acc <= o_acc_next;
        end
    end

endmodule : alu_iter_mul
`default_nettype wire

// File: rtl/alu_responder.sv
`default_nettype none
// ============================================================================
// Module   : alu_responder
// Brief    : Handshaked ALU execution unit. Accepts one request at a time,
//            resolves logic/add/sub in the accept cycle, iterates SHL (one bit
//            per cycle) and MUL (one multiplier bit per cycle), and holds the
//            result on the response channel until it is consumed.
// Revision : 1.0 - initial release
// ============================================================================
module alu_responder
    import alu_pkg::*;
#(
    parameter int WIDTH      = ALU_WIDTH,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_mul;
    logic [WIDTH-1:0] r_shacc;
    logic [WIDTH-1:0] r_data;
    logic             r_carry;
    logic             r_zero;
    logic             r_err;

    logic [4:0]       w_shamt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_err;
    logic             w_iter;
    logic             w_accept;
    logic             w_mul_start;
    logic             w_mul_step;
    logic [WIDTH-1:0] w_mul_next;
    logic [WIDTH-1:0] w_iter_res;

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_DONE);
    assign rsp_data  = r_data;
    assign rsp_carry = r_carry;
    assign rsp_zero  = r_zero;
    assign rsp_err   = r_err;

    assign w_accept    = req_ready && req_valid;
    assign w_shamt     = req_b[4:0];
    assign w_sum       = {1'b0, req_a} + {1'b0, req_b};
    assign w_diff      = {1'b0, req_a} + {1'b0, ~req_b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_mul_start = w_accept && (req_op == OP_MUL);
    assign w_mul_step  = (r_state == ST_BUSY) && r_is_mul;
    assign w_iter_res  = r_is_mul ? w_mul_next : (r_shacc << 1);

    // Accept-cycle datapath; a zero-distance SHL is resolved here as well.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        w_iter  = 1'b0;
        case (req_op)
            OP_NOT: w_res = ~req_a;
            OP_AND: w_res = req_a & req_b;
            OP_OR:  w_res = req_a | req_b;
            OP_XOR: w_res = req_a ^ req_b;
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            OP_SHL: begin
                w_res  = req_a;
                w_iter = (w_shamt != 5'd0);
            end
            OP_MUL: w_iter = 1'b1;
            default: w_err = 1'b1;
        endcase
    end

    alu_iter_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_mul_start),
        .i_step     (w_mul_step),
        .i_a        (req_a),
        .i_b        (req_b),
        .o_acc_next (w_mul_next)
    );

    // Control FSM plus registered response; the result only changes on the
    // transition into DONE so it stays stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_is_mul <= 1'b0;
            r_shacc  <= '0;
            r_data   <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_is_mul <= (req_op == OP_MUL);
                        r_shacc  <= req_a;
                        if (w_iter) begin
                            r_state <= ST_BUSY;
                            r_cnt   <= (req_op == OP_MUL) ? CNT_W'(MUL_CYCLES)
                                                          : CNT_W'(w_shamt);
                        end else begin
                            r_state <= ST_DONE;
                            r_data  <= w_res;
                            r_carry <= w_carry;
                            r_zero  <= (w_res == '0);
                            r_err   <= w_err;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt   <= r_cnt - CNT_W'(1);
                    r_shacc <= r_shacc << 1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_DONE;
                        r_data  <= w_iter_res;
                        r_carry <= 1'b0;
                        r_zero  <= (w_iter_res == '0);
                        r_err   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : alu_responder
`default_nettype wire

// File: tb/tb_alu_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_responder
// Brief    : Directed self-checking bench for alu_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_zero;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    alu_responder u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for its result, leaving rsp_ready low so
    // the caller decides when to consume it.
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat);
        int lat;
        int guard;
        guard = 0;
        while (!req_ready && guard < 100) begin
            tick();
            guard++;
        end
        chk({tag, ".ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            chk({tag, ".busy_ready"}, req_ready, 1'b0);
            tick();
            lat++;
        end
        chk({tag, ".latency"}, lat, exp_lat);
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] d, input logic c,
                              input logic z, input logic e);
        chk({tag, ".valid"}, rsp_valid, 1'b1);
        chk({tag, ".data"},  rsp_data,  d);
        chk({tag, ".carry"}, rsp_carry, c);
        chk({tag, ".zero"},  rsp_zero,  z);
        chk({tag, ".err"},   rsp_err,   e);
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, ".idle_valid"}, rsp_valid, 1'b0);
        chk({tag, ".idle_ready"}, req_ready, 1'b1);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [31:0] d,
                       input logic c, input logic z, input logic e);
        issue(tag, op, a, b, lat);
        expect_rsp(tag, d, c, z, e);
        consume(tag);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst.ready", req_ready, 1'b1);
        chk("rst.valid", rsp_valid, 1'b0);
        chk("rst.data",  rsp_data,  32'd0);
        chk("rst.carry", rsp_carry, 1'b0);
        chk("rst.zero",  rsp_zero,  1'b0);
        chk("rst.err",   rsp_err,   1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run("not",     4'd0, 32'd5,          32'd0,          1,  32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0);
        run("add_c",   4'd4, 32'hFFFF_FFFF,  32'd1,          1,  32'd0,         1'b1, 1'b1, 1'b0);
        run("add",     4'd4, 32'd100,        32'd23,         1,  32'd123,       1'b0, 1'b0, 1'b0);
        run("sub_b",   4'd5, 32'd3,          32'd5,          1,  32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run("sub",     4'd5, 32'd5,          32'd3,          1,  32'd2,         1'b1, 1'b0, 1'b0);
        run("sub_eq",  4'd5, 32'd7,          32'd7,          1,  32'd0,         1'b1, 1'b1, 1'b0);
        run("and",     4'd1, 32'hF0F0_F0F0,  32'hFF00_FF00,  1,  32'hF000_F000, 1'b0, 1'b0, 1'b0);
        run("or",      4'd2, 32'h1200_0034,  32'h0056_7800,  1,  32'h1256_7834, 1'b0, 1'b0, 1'b0);
        run("xor",     4'd3, 32'hAAAA_5555,  32'hFFFF_FFFF,  1,  32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
        run("mul",     4'd7, 32'd7,          32'd6,          33, 32'd42,        1'b0, 1'b0, 1'b0);
        run("mul_big", 4'd7, 32'd12345,      32'd678,        33, 32'd8369910,   1'b0, 1'b0, 1'b0);
        run("mul_ff",  4'd7, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  33, 32'd1,         1'b0, 1'b0, 1'b0);
        run("mul_tr",  4'd7, 32'h0001_0000,  32'h0001_0000,  33, 32'd0,         1'b0, 1'b1, 1'b0);
        run("shl4",    4'd6, 32'd1,          32'd4,          5,  32'd16,        1'b0, 1'b0, 1'b0);
        run("shl0",    4'd6, 32'd1,          32'd0,          1,  32'd1,         1'b0, 1'b0, 1'b0);
        run("shl_msk", 4'd6, 32'd3,          32'h0000_0021,  2,  32'd6,         1'b0, 1'b0, 1'b0);
        run("shl31",   4'd6, 32'd3,          32'd31,         32, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        run("illegal", 4'd9, 32'h1234_5678,  32'd1,          1,  32'd0,         1'b0, 1'b1, 1'b1);

        // Backpressure: result must hold for 10 cycles without rsp_ready
        issue("bp", 4'd4, 32'h8000_0000, 32'h8000_0001, 1);
        for (int i = 0; i < 10; i++) begin
            expect_rsp("bp_hold", 32'd1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        consume("bp");
        // Next request goes in at the very next edge
        run("bp_next", 4'd0, 32'd0, 32'd0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Reset during MUL BUSY: previous result is nonzero so reset is visible
        run("pre_rst", 4'd0, 32'd5, 32'd0, 1, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0);
        req_valid = 1'b1;
        req_op    = 4'd7;
        req_a     = 32'd7;
        req_b     = 32'd6;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.ready", req_ready, 1'b1);
        chk("mrst.valid", rsp_valid, 1'b0);
        chk("mrst.data",  rsp_data,  32'd0);
        chk("mrst.carry", rsp_carry, 1'b0);
        chk("mrst.zero",  rsp_zero,  1'b0);
        chk("mrst.err",   rsp_err,   1'b0);
        tick();
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (rsp_valid) seen++;
                tick();
            end
            chk("mrst.no_rsp", seen, 0);
        end
        run("post_rst", 4'd0, 32'd5, 32'd0, 1, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_alu_responder
`default_nettype wire
